// File: rtl/imem_arb_pkg.sv
// -----------------------------------------------------------------------------
// imem_arb_pkg
// Shared constants and types for the instruction/coefficient memory arbiter.
//   IMEM_ADDR_W        : word address width of the 16K x 16 memory
//   IMEM_DATA_W        : memory word width
//   IMEM_STARVE_LIMIT  : default bound on fetch grants while the loader waits
//   STARVE_W           : width of the starvation counter (limit range 1..255)
//   owner_e            : which requester owns the read response in flight
// -----------------------------------------------------------------------------
package imem_arb_pkg;

  localparam int IMEM_ADDR_W       = 14;
  localparam int IMEM_DATA_W       = 16;
  localparam int IMEM_STARVE_LIMIT = 8;
  localparam int STARVE_W          = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_FE   = 2'd1,
    OWN_LD   = 2'd2
  } owner_e;

endpackage : imem_arb_pkg

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
// Shares one single-ported synchronous memory (1-cycle read latency) between
// the FIR sequencer fetch port (read-only) and the host loader port (R/W).
// Fetch has priority; a starvation counter bounds how long the loader waits,
// and LD_LOCK hands the memory exclusively to the loader during download.
//
// Ports
//   CLK, RSTN                  : clock, asynchronous active-low reset
//   FE_REQ/FE_ADDR/FE_GNT      : fetch read request channel
//   FE_RVALID/FE_RDATA         : fetch read response (one cycle after grant)
//   LD_REQ/LD_WE/LD_ADDR/
//   LD_WDATA/LD_LOCK/LD_GNT    : loader request channel and exclusive lock
//   LD_RVALID/LD_RDATA         : loader read response (reads only)
//   IMEM_CEN/WEN/A/D           : memory pins (CEN, WEN active-low)
//   IMEM_Q                     : memory read data, valid the cycle after a read
//
// Handshake: a requester raises REQ with a stable payload and keeps both
// unchanged until it sees GNT high; the transfer happens on the rising edge
// where REQ and GNT are both high. GNT is combinational from REQ, so a
// requester may drop or change REQ in the cycle after that edge. Responses
// carry no ready: RVALID is a one-cycle strobe the requester must accept.
// -----------------------------------------------------------------------------
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W       = IMEM_ADDR_W,
  parameter int DATA_W       = IMEM_DATA_W,
  parameter int STARVE_LIMIT = IMEM_STARVE_LIMIT
) (
  input  logic              CLK,
  input  logic              RSTN,
  // fetch port
  input  logic              FE_REQ,
  input  logic [ADDR_W-1:0] FE_ADDR,
  output logic              FE_GNT,
  output logic              FE_RVALID,
  output logic [DATA_W-1:0] FE_RDATA,
  // loader port
  input  logic              LD_REQ,
  input  logic              LD_WE,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [DATA_W-1:0] LD_WDATA,
  input  logic              LD_LOCK,
  output logic              LD_GNT,
  output logic              LD_RVALID,
  output logic [DATA_W-1:0] LD_RDATA,
  // memory pins
  output logic              IMEM_CEN,
  output logic              IMEM_WEN,
  output logic [ADDR_W-1:0] IMEM_A,
  output logic [DATA_W-1:0] IMEM_D,
  input  logic [DATA_W-1:0] IMEM_Q
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;
  owner_e              owner_q;
  owner_e              owner_d;
  logic [DATA_W-1:0]   fe_hold_q;
  logic [DATA_W-1:0]   ld_hold_q;

  // ---------------------------------------------------------------------------
  // Grant: one access per cycle. Grants are forced low while RSTN is asserted
  // so the memory stays deselected during reset whatever the requesters do.
  // ---------------------------------------------------------------------------
  always_comb begin
    FE_GNT = 1'b0;
    LD_GNT = 1'b0;
    if (RSTN) begin
      if (LD_LOCK) begin
        LD_GNT = LD_REQ;
      end else if (LD_REQ && (starve_cnt == STARVE_MAX)) begin
        LD_GNT = 1'b1;
      end else if (FE_REQ) begin
        FE_GNT = 1'b1;
      end else begin
        LD_GNT = LD_REQ;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory drive: pins come from whichever port won; parked at zero when idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    IMEM_CEN = 1'b1;
    IMEM_WEN = 1'b1;
    IMEM_A   = '0;
    IMEM_D   = '0;
    if (FE_GNT) begin
      IMEM_CEN = 1'b0;
      IMEM_A   = FE_ADDR;
    end else if (LD_GNT) begin
      IMEM_CEN = 1'b0;
      IMEM_WEN = ~LD_WE;
      IMEM_A   = LD_ADDR;
      IMEM_D   = LD_WDATA;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: counts fetch grants taken while the loader is waiting.
  // Any loader grant, or the loader withdrawing, restarts the count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      starve_cnt <= '0;
    end else if (!LD_REQ || LD_GNT) begin
      starve_cnt <= '0;
    end else if (FE_GNT && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Response owner: remembers who issued the read so IMEM_Q is routed to the
  // right port in the following cycle. Writes leave no owner.
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_d = OWN_NONE;
    if (FE_GNT) begin
      owner_d = OWN_FE;
    end else if (LD_GNT && !LD_WE) begin
      owner_d = OWN_LD;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      owner_q   <= OWN_NONE;
      fe_hold_q <= '0;
      ld_hold_q <= '0;
    end else begin
      owner_q <= owner_d;
      // Capture the passed-through word so the port keeps showing it after
      // the memory output moves on to someone else's read.
      if (owner_q == OWN_FE) fe_hold_q <= IMEM_Q;
      if (owner_q == OWN_LD) ld_hold_q <= IMEM_Q;
    end
  end

  assign FE_RVALID = (owner_q == OWN_FE);
  assign LD_RVALID = (owner_q == OWN_LD);
  assign FE_RDATA  = FE_RVALID ? IMEM_Q : fe_hold_q;
  assign LD_RDATA  = LD_RVALID ? IMEM_Q : ld_hold_q;

endmodule : imem_arbiter

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
// Directed bench for imem_arbiter with a behavioural 16K x 16 single-port
// memory (registered read, write-first on the array).
// -----------------------------------------------------------------------------
module tb_imem_arbiter;
  import imem_arb_pkg::*;

  localparam int AW = IMEM_ADDR_W;
  localparam int DW = IMEM_DATA_W;

  // ---------------------------------------------------------------- clock/reset
  logic          CLK = 1'b0;
  logic          RSTN;
  always #5 CLK = ~CLK;

  logic          FE_REQ;
  logic [AW-1:0] FE_ADDR;
  logic          FE_GNT;
  logic          FE_RVALID;
  logic [DW-1:0] FE_RDATA;
  logic          LD_REQ;
  logic          LD_WE;
  logic [AW-1:0] LD_ADDR;
  logic [DW-1:0] LD_WDATA;
  logic          LD_LOCK;
  logic          LD_GNT;
  logic          LD_RVALID;
  logic [DW-1:0] LD_RDATA;
  logic          IMEM_CEN;
  logic          IMEM_WEN;
  logic [AW-1:0] IMEM_A;
  logic [DW-1:0] IMEM_D;
  logic [DW-1:0] IMEM_Q;

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(8)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .FE_REQ(FE_REQ), .FE_ADDR(FE_ADDR), .FE_GNT(FE_GNT),
    .FE_RVALID(FE_RVALID), .FE_RDATA(FE_RDATA),
    .LD_REQ(LD_REQ), .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_WDATA(LD_WDATA),
    .LD_LOCK(LD_LOCK), .LD_GNT(LD_GNT),
    .LD_RVALID(LD_RVALID), .LD_RDATA(LD_RDATA),
    .IMEM_CEN(IMEM_CEN), .IMEM_WEN(IMEM_WEN), .IMEM_A(IMEM_A),
    .IMEM_D(IMEM_D), .IMEM_Q(IMEM_Q)
  );

  // ---------------------------------------------------------------- memory model
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    IMEM_Q = '0;
  end
  always @(posedge CLK) begin
    if (!IMEM_CEN) begin
      if (!IMEM_WEN) mem[IMEM_A] <= IMEM_D;
      else           IMEM_Q      <= mem[IMEM_A];
    end
  end

  // ---------------------------------------------------------------- scoreboard
  int            n_vec = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // A "cycle" starts 1ns after a rising edge (inputs driven) and is checked at
  // the falling edge, well away from the active edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    FE_REQ   = 1'b0;
    FE_ADDR  = '0;
    LD_REQ   = 1'b0;
    LD_WE    = 1'b0;
    LD_ADDR  = '0;
    LD_WDATA = '0;
  endtask

  task automatic ld_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    LD_REQ   = 1'b1;
    LD_WE    = 1'b1;
    LD_ADDR  = addr;
    LD_WDATA = data;
    mid();
    check("preload_ld_gnt", 32'(LD_GNT), 32'd1);
    next_cycle();
    idle_inputs();
  endtask

  // back-to-back table: fetch/loader select, address, expected word
  bit            t_fe   [4];
  logic [AW-1:0] t_addr [4];
  logic [DW-1:0] t_data [4];
  logic [DW-1:0] exp_w;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin : main
    idle_inputs();
    LD_LOCK = 1'b0;
    RSTN    = 1'b0;
    FE_REQ  = 1'b1;
    LD_REQ  = 1'b1;

    // ---- reset with both requests asserted
    repeat (2) next_cycle();
    mid();
    check("rst_cen",       32'(IMEM_CEN),  32'd1);
    check("rst_fe_gnt",    32'(FE_GNT),    32'd0);
    check("rst_ld_gnt",    32'(LD_GNT),    32'd0);
    check("rst_fe_rvalid", 32'(FE_RVALID), 32'd0);
    check("rst_ld_rvalid", 32'(LD_RVALID), 32'd0);
    next_cycle();
    RSTN = 1'b1;
    mid();
    check("rel_fe_gnt", 32'(FE_GNT), 32'd1);
    check("rel_ld_gnt", 32'(LD_GNT), 32'd0);
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();

    // ---- loader write 0x1234 <= 0xBEEF, then fetch read 0x1234
    LD_REQ   = 1'b1;
    LD_WE    = 1'b1;
    LD_ADDR  = 14'h1234;
    LD_WDATA = 16'hBEEF;
    mid();
    check("wr_ld_gnt", 32'(LD_GNT),   32'd1);
    check("wr_fe_gnt", 32'(FE_GNT),   32'd0);
    check("wr_cen",    32'(IMEM_CEN), 32'd0);
    check("wr_wen",    32'(IMEM_WEN), 32'd0);
    check("wr_addr",   32'(IMEM_A),   32'h1234);
    check("wr_data",   32'(IMEM_D),   32'hBEEF);
    next_cycle();
    idle_inputs();
    FE_REQ  = 1'b1;
    FE_ADDR = 14'h1234;
    mid();
    check("rd_fe_gnt",      32'(FE_GNT),    32'd1);
    check("rd_wen",         32'(IMEM_WEN),  32'd1);
    check("rd_addr",        32'(IMEM_A),    32'h1234);
    check("wr_no_ld_rvalid",32'(LD_RVALID), 32'd0);
    check("wr_no_fe_rvalid",32'(FE_RVALID), 32'd0);
    next_cycle();
    idle_inputs();
    mid();
    check("rd_fe_rvalid", 32'(FE_RVALID), 32'd1);
    check("rd_fe_rdata",  32'(FE_RDATA),  32'hBEEF);
    check("rd_ld_rvalid", 32'(LD_RVALID), 32'd0);
    check("idle_cen",     32'(IMEM_CEN),  32'd1);
    check("idle_wen",     32'(IMEM_WEN),  32'd1);
    check("idle_addr",    32'(IMEM_A),    32'h0);
    next_cycle();
    mid();
    check("rd_fe_rvalid_once", 32'(FE_RVALID), 32'd0);
    next_cycle();

    // ---- starvation: two rounds of 8 fetch grants then one loader grant
    FE_REQ  = 1'b1;
    FE_ADDR = 14'h1234;
    LD_REQ  = 1'b1;
    LD_WE   = 1'b0;
    LD_ADDR = 14'h0005;
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 8; k++) begin
        mid();
        check("starve_fe_gnt", 32'(FE_GNT), 32'd1);
        check("starve_ld_wait", 32'(LD_GNT), 32'd0);
        if (r == 1 && k == 1) begin
          check("starve_ld_rvalid", 32'(LD_RVALID), 32'd1);
          check("starve_fe_no_rv",  32'(FE_RVALID), 32'd0);
        end
        next_cycle();
      end
      mid();
      check("starve_ld_gnt",   32'(LD_GNT), 32'd1);
      check("starve_fe_block", 32'(FE_GNT), 32'd0);
      check("starve_addr",     32'(IMEM_A), 32'h0005);
      next_cycle();
    end
    idle_inputs();
    mid();
    check("starve_ld_rvalid2", 32'(LD_RVALID), 32'd1);
    check("starve_ld_rdata",   32'(LD_RDATA),  32'h0);
    next_cycle();

    // ---- lock: fetch read outstanding when lock rises still completes
    FE_REQ  = 1'b1;
    FE_ADDR = 14'h1234;
    mid();
    check("prelock_fe_gnt", 32'(FE_GNT), 32'd1);
    next_cycle();
    LD_LOCK = 1'b1;
    LD_WE   = 1'b0;
    LD_ADDR = 14'h0100;
    for (int i = 0; i < 6; i++) begin
      LD_REQ = (i % 2 == 0);
      mid();
      if (i == 0) begin
        check("lock_fe_rvalid", 32'(FE_RVALID), 32'd1);
        check("lock_fe_rdata",  32'(FE_RDATA),  32'hBEEF);
      end
      check("lock_fe_gnt", 32'(FE_GNT),   32'd0);
      check("lock_ld_gnt", 32'(LD_GNT),   (i % 2 == 0) ? 32'd1 : 32'd0);
      check("lock_cen",    32'(IMEM_CEN), (i % 2 == 0) ? 32'd0 : 32'd1);
      next_cycle();
    end
    LD_LOCK = 1'b0;
    LD_REQ  = 1'b0;
    mid();
    check("unlock_fe_gnt", 32'(FE_GNT), 32'd1);
    next_cycle();
    idle_inputs();
    next_cycle();

    // ---- back-to-back mixed reads
    ld_write(14'h0000, 16'h0A0A);
    ld_write(14'h3FFF, 16'hFFFF);
    ld_write(14'h0100, 16'h1111);
    t_fe   = '{1'b1, 1'b0, 1'b1, 1'b0};
    t_addr = '{14'h0000, 14'h0100, 14'h3FFF, 14'h0100};
    t_data = '{16'h0A0A, 16'h1111, 16'hFFFF, 16'h1111};
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      if (i < 4) begin
        if (t_fe[i]) begin
          FE_REQ  = 1'b1;
          FE_ADDR = t_addr[i];
        end else begin
          LD_REQ  = 1'b1;
          LD_ADDR = t_addr[i];
        end
        exp_q.push_back(t_data[i]);
      end
      mid();
      if (i < 4) check("b2b_gnt", 32'(t_fe[i] ? FE_GNT : LD_GNT), 32'd1);
      if (i > 0) begin
        exp_w = exp_q.pop_front();
        if (t_fe[i-1]) begin
          check("b2b_fe_rvalid", 32'(FE_RVALID), 32'd1);
          check("b2b_fe_rdata",  32'(FE_RDATA),  32'(exp_w));
          check("b2b_ld_quiet",  32'(LD_RVALID), 32'd0);
        end else begin
          check("b2b_ld_rvalid", 32'(LD_RVALID), 32'd1);
          check("b2b_ld_rdata",  32'(LD_RDATA),  32'(exp_w));
          check("b2b_fe_quiet",  32'(FE_RVALID), 32'd0);
        end
      end
      if (i == 2) check("b2b_fe_hold", 32'(FE_RDATA), 32'h0A0A);
      if (i == 3) check("b2b_ld_hold", 32'(LD_RDATA), 32'h1111);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // ---- async reset half a cycle into a fetch read grant
    FE_REQ  = 1'b1;
    FE_ADDR = 14'h0000;
    mid();
    check("arst_fe_gnt", 32'(FE_GNT), 32'd1);
    RSTN = 1'b0;
    #1;
    check("arst_gnt_drop", 32'(FE_GNT),   32'd0);
    check("arst_cen",      32'(IMEM_CEN), 32'd1);
    next_cycle();
    FE_REQ = 1'b0;
    mid();
    check("arst_fe_rvalid_in", 32'(FE_RVALID), 32'd0);
    next_cycle();
    RSTN = 1'b1;
    mid();
    check("arst_fe_rvalid_rel", 32'(FE_RVALID), 32'd0);
    check("arst_ld_rvalid_rel", 32'(LD_RVALID), 32'd0);
    next_cycle();
    mid();
    check("arst_fe_rvalid_after", 32'(FE_RVALID), 32'd0);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_imem_arbiter
